// File: rtl/alu_cmd_sender.sv
// alu_cmd_sender: accepts an ALU command (A, B, op) over a valid/ready handshake
// and serialises it onto the ALU's sin line as nine 11-bit packets (99 bits),
// MSB first. The last packet carries the op code plus a CRC-4 over {A, B, 1, op}.
module alu_cmd_sender #(
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam logic [6:0] FRAME_BITS = 7'd99;
    localparam logic [3:0] GAP_LEN    = 4'(IDLE_GAP);

    // CRC-4, x^4+x+1, zero init, augmented: feed the 68 message bits, then four zeros.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3];
            c  = {c[2:0], msg[i]};
            if (fb) c = c ^ 4'b0011;
        end
        for (int i = 0; i < 4; i++) begin
            fb = c[3];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    // One packet: start bit 0, type bit (1 = command), payload MSB first, stop bit 1.
    function automatic logic [10:0] packet(input logic is_cmd, input logic [7:0] payload);
        return {1'b0, is_cmd, payload, 1'b1};
    endfunction

    function automatic logic [98:0] build_frame(input logic [31:0] a, input logic [31:0] b,
                                                input logic [2:0] op);
        logic [3:0] crc;
        crc = crc4({a, b, 1'b1, op});
        return {packet(1'b0, a[31:24]), packet(1'b0, a[23:16]),
                packet(1'b0, a[15:8]),  packet(1'b0, a[7:0]),
                packet(1'b0, b[31:24]), packet(1'b0, b[23:16]),
                packet(1'b0, b[15:8]),  packet(1'b0, b[7:0]),
                packet(1'b1, {1'b0, op, crc})};
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [98:0] shreg_q, shreg_d;
    logic        sin_q, sin_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [98:0] frame_w;

    assign frame_w   = build_frame(req_a, req_b, req_op);
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sin       = sin_q;

    // Next-state logic: capture the frame on handshake, shift one bit per clock, then idle gap.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        sin_d     = 1'b1;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    sin_d     = frame_w[98];
                    shreg_d   = {frame_w[97:0], 1'b0};
                    bit_cnt_d = 7'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == FRAME_BITS) begin
                    done_d    = 1'b1;
                    bit_cnt_d = 7'd0;
                    shreg_d   = '0;
                    if (IDLE_GAP > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sin_d     = shreg_q[98];
                    shreg_d   = {shreg_q[97:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q >= GAP_LEN) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 7'd0;
            gap_cnt_q <= 4'd0;
            shreg_q   <= '0;
            sin_q     <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            sin_q     <= sin_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
   end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Testbench for alu_cmd_sender: one instance with the default two-cycle idle gap and
// one with no gap; expected frames are queued at handshake and compared on completion.
module tb_alu_cmd_sender;

   logic        clk;
   logic        rstN;
   logic        reqValid;
   logic [31:0] reqA;
   logic [31:0] reqB;
   logic [2:0]  reqOp;
   logic        sel;

   logic rdy2, sin2, busy2, done2;
   logic rdy0, sin0, busy0, done0;
   logic curReady, curSin, curBusy, curDone;

   int assertCount = 0;
   int failCount   = 0;
   logic [98:0] expQueue[$];
   logic [98:0] lastFrame;
   time hsTime;
   time prevHsTime;

   alu_cmd_sender #(.IDLE_GAP(2)) dutGap2 (
      .clk(clk), .rst_n(rstN), .req_valid(reqValid & ~sel), .req_ready(rdy2),
      .req_a(reqA), .req_b(reqB), .req_op(reqOp), .sin(sin2), .busy(busy2), .done(done2)
   );

   alu_cmd_sender #(.IDLE_GAP(0)) dutGap0 (
      .clk(clk), .rst_n(rstN), .req_valid(reqValid & sel), .req_ready(rdy0),
      .req_a(reqA), .req_b(reqB), .req_op(reqOp), .sin(sin0), .busy(busy0), .done(done0)
   );

   assign curReady = sel ? rdy0  : rdy2;
   assign curSin   = sel ? sin0  : sin2;
   assign curBusy  = sel ? busy0 : busy2;
   assign curDone  = sel ? done0 : done2;

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference CRC by long division of {msg, 0000} by 10011.
   function automatic logic [3:0] refCrc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      logic [71:0] r;
      r = {a, b, 1'b1, op, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   function automatic logic [98:0] refFrame(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
      logic [98:0] f;
      logic [63:0] data;
      data = {a, b};
      f = '0;
      for (int p = 0; p < 8; p++)
         f[98 - 11*p -: 11] = {2'b00, data[63 - 8*p -: 8], 1'b1};
      f[10:0] = {2'b01, 1'b0, op, refCrc(a, b, op), 1'b1};
      return f;
   endfunction

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
      end
   endtask

   // Send one command on the selected instance and collect/check its frame.
   // Entered and left on a falling edge. abortAt >= 0 pulses reset after that bit.
   task automatic applyStimulus(input bit useGap0, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input bit holdValid,
                                input int mutateAt, input int abortAt);
      int waitCnt;
      logic [98:0] got;
      logic [98:0] exp;
      bit doneEarly, busyBad, readyBad;
      sel      = useGap0;
      reqA     = a;
      reqB     = b;
      reqOp    = op;
      reqValid = 1'b1;
      waitCnt  = 0;
      doneEarly = 0; busyBad = 0; readyBad = 0;
      while (curReady !== 1'b1 && waitCnt < 500) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 500) begin
         checkOutput("handshake_timeout", 1, 0);
         reqValid = 1'b0;
         return;
      end
      expQueue.push_back(refFrame(a, b, op));
      @(posedge clk);
      prevHsTime = hsTime;
      hsTime     = $time;
      #1 reqValid = holdValid;
      for (int k = 0; k < 99; k++) begin
         @(negedge clk);
         got[98 - k] = curSin;
         if (curDone !== 1'b0) doneEarly = 1;
         if (curReady !== 1'b0) readyBad = 1;
         if (curBusy !== 1'b1) busyBad = 1;
         if (k == mutateAt) begin
            reqA  = 32'hFFFF_FFFF;
            reqB  = 32'hFFFF_FFFF;
            reqOp = 3'b111;
         end
         if (k == abortAt) begin
            #2 rstN = 1'b0;
            #1;
            checkOutput("abort_sin", curSin, 1'b1);
            checkOutput("abort_ready", curReady, 1'b0);
            checkOutput("abort_busy", curBusy, 1'b0);
            checkOutput("abort_done", curDone, 1'b0);
            void'(expQueue.pop_front());
            reqValid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rstN = 1'b1;
            doneEarly = 0;
            for (int j = 0; j < 120; j++) begin
               @(negedge clk);
               if (curDone !== 1'b0 || curSin !== 1'b1) doneEarly = 1;
            end
            checkOutput("abort_no_resume", doneEarly, 0);
            checkOutput("abort_ready_back", curReady, 1'b1);
            return;
         end
      end
      checkOutput("done_during_frame", doneEarly, 0);
      checkOutput("ready_during_frame", readyBad, 0);
      checkOutput("busy_during_frame", busyBad, 0);
      @(negedge clk);
      checkOutput("done_pulse", curDone, 1'b1);
      checkOutput("sin_after_frame", curSin, 1'b1);
      checkOutput("ready_after_frame", curReady, useGap0);
      exp = expQueue.pop_front();
      checkOutput("frame", got, exp);
      lastFrame = got;
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rstN = 1'b0; reqValid = 1'b0; reqA = '0; reqB = '0; reqOp = '0; sel = 1'b0;
      hsTime = 0; prevHsTime = 0;

      // Reset state
      @(negedge clk);
      checkOutput("rst_sin", sin2, 1'b1);
      checkOutput("rst_ready", rdy2, 1'b0);
      checkOutput("rst_busy", busy2, 1'b0);
      checkOutput("rst_done", done2, 1'b0);
      checkOutput("rst_sin_g0", sin0, 1'b1);
      @(negedge clk);
      rstN = 1'b1;
      #1 checkOutput("ready_before_edge", rdy2, 1'b0);
      @(negedge clk);
      checkOutput("ready_after_edge", rdy2, 1'b1);
      checkOutput("busy_after_edge", busy2, 1'b0);
      checkOutput("ready_after_edge_g0", rdy0, 1'b1);

      // All-zero command: CMD payload 0x0B
      applyStimulus(0, 32'd0, 32'd0, 3'b000, 0, -1, -1);
      checkOutput("cmd_payload_zero", lastFrame[8:1], 8'h0B);
      checkOutput("cmd_type_bit", lastFrame[9], 1'b1);
      checkOutput("data_type_bit", lastFrame[97], 1'b0);
      @(negedge clk);
      checkOutput("gap_sin_2", curSin, 1'b1);

      // A=10, B=20: CRC comes out zero
      applyStimulus(0, 32'd10, 32'd20, 3'b000, 0, -1, -1);
      checkOutput("payload_a_lsb", lastFrame[63:56], 8'h0A);
      checkOutput("payload_b_lsb", lastFrame[19:12], 8'h14);
      checkOutput("cmd_payload_10_20", lastFrame[8:1], 8'h00);
      @(negedge clk);

      // ADD with operands changed mid-frame; valid held so the next request waits through the gap
      applyStimulus(0, 32'd0, 32'd0, 3'b100, 1, 50, -1);
      checkOutput("cmd_payload_add", lastFrame[8:1], 8'h47);
      @(negedge clk);
      checkOutput("gap_sin_held", curSin, 1'b1);
      checkOutput("gap_ready_held", curReady, 1'b0);
      applyStimulus(0, 32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 0, -1, -1);
      checkOutput("spacing_gap2", (hsTime - prevHsTime) / 10, 102);
      @(negedge clk);

      // Back-to-back frames with no gap
      applyStimulus(1, 32'hA5A5_0F0F, 32'h0000_FFFF, 3'b001, 1, -1, -1);
      for (int n = 0; n < 2; n++) begin
         applyStimulus(1, $urandom, $urandom, 3'($urandom_range(7)), 1, -1, -1);
         checkOutput("spacing_gap0", (hsTime - prevHsTime) / 10, 100);
      end
      reqValid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of a frame, then a full clean frame
      applyStimulus(0, 32'h0F0F_F0F0, 32'h8000_0001, 3'b100, 0, -1, 40);
      applyStimulus(0, 32'h1357_9BDF, 32'h2468_ACE0, 3'b001, 0, -1, -1);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sender.md
ALU_CMD_SENDER -- requirements
Module: alu_cmd_sender

Interface
REQ-001 Parameter IDLE_GAP, default 2, meaning idle-high sin cycles inserted after each frame's final stop bit (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester has a command on req_a/req_b/req_op.
REQ-005 req_ready  output  1  sender can accept a command this cycle.
REQ-006 req_a  input  32  first operand A.
REQ-007 req_b  input  32  second operand B.
REQ-008 req_op  input  3  ALU operation code (000 AND, 001 OR, 100 ADD, 101 SUB; other codes sent unchanged).
REQ-009 sin  output  1  serial stream to the ALU sin input, registered, idle level 1.
REQ-010 busy  output  1  high from acceptance until req_ready reasserts.
REQ-011 done  output  1  one-cycle pulse marking end of frame.

Function
REQ-012 Handshake SHALL complete on a rising edge with req_valid=1 and req_ready=1; req_a/req_b/req_op SHALL be captured on that edge, and later changes SHALL be ignored until the next handshake.
REQ-013 req_ready SHALL be 1 only in state IDLE; req_valid while not ready SHALL be held off with no effect, and req_valid need not be held once accepted.
REQ-014 FSM states: IDLE -> SHIFT on handshake; SHIFT -> GAP after 99th bit when IDLE_GAP>0, else SHIFT -> IDLE; GAP -> IDLE after IDLE_GAP cycles.
REQ-015 Frame = 9 packets of 11 bits, 99 bits, sent MSB first, one bit per clock: A[31:24], A[23:16], A[15:8], A[7:0], B[31:24], B[23:16], B[15:8], B[7:0], CMD.
REQ-016 Data packet bits: 0, 0, payload[7:0] MSB first, 1; CMD packet bits: 0, 1, payload[7:0] MSB first, 1.
REQ-017 CMD payload SHALL be {1'b0, op[2:0], crc[3:0]}.
REQ-018 crc SHALL be CRC-4, polynomial x^4+x+1, initial value 0000, computed over the 68-bit message {A, B, 1'b1, op}, MSB first, augmented form (message times x^4 mod poly); serial or parallel computation permitted, bit timing unchanged.
REQ-019 First frame bit (start bit of A[31:24] packet) SHALL appear on sin in the cycle following the handshake edge; bit k (0..98) SHALL be held on sin during cycle k+1 after the handshake edge.
REQ-020 sin SHALL be 1 in IDLE and GAP.
REQ-021 done SHALL pulse for exactly one cycle, the cycle immediately after the last stop bit (first GAP cycle, or first IDLE cycle when IDLE_GAP=0).
REQ-022 With IDLE_GAP=0 and req_valid held high, frames SHALL be back-to-back: 100 cycles from one handshake to the next, with exactly one sin=1 cycle between frames.
REQ-023 With IDLE_GAP=G, handshake-to-handshake spacing SHALL be 100+G cycles minimum.
REQ-024 busy SHALL equal NOT req_ready outside reset.

Reset
REQ-025 rst_n low SHALL immediately force sin=1, req_ready=0, busy=0, done=0, state IDLE, and clear bit/gap counters and CRC state, including mid-frame (partial frame abandoned, never resumed).
REQ-026 req_ready SHALL rise on the first rising edge with rst_n high; no handshake SHALL occur before that edge.

Verification
REQ-027 A=0, B=0, op=000 -> 99 bits match REQ-015/016, CMD payload 0x0B, done one pulse 100 cycles after the handshake edge.
REQ-028 A=10, B=20, op=000 -> data payloads 00,00,00,0A,00,00,00,14, CMD payload 0x00.
REQ-029 A=0, B=0, op=100 -> CMD payload 0x47; req_a changed to 0xFFFFFFFF mid-frame -> no change to transmitted bits.
REQ-030 IDLE_GAP=0, req_valid held high, three commands -> frames 100 cycles apart, single sin=1 cycle between frames, req_ready high exactly one cycle per frame.
REQ-031 rst_n pulsed low at bit 40 -> sin=1 at once, no done pulse, next command after release sent as a complete correct 99-bit frame.
REQ-032 IDLE_GAP=2, req_valid asserted while busy -> held off, handshake 102 cycles after previous handshake, sin=1 during both gap cycles.
